uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Byte buffer directly downstream of the UART receiver. Captures each byte the receiver
//  flags complete (RX_STATUS pulse with RX_DATA) into a circular FIFO so the CPU
//  peripheral logic can read bytes at its own pace without losing back-to-back frames.
//  Runs entirely on br_clk_16. The read side is a single-cycle request strobe.
// PARAMETERS
//  DEPTH       16  number of byte slots; power of two, >= 2
//  ADDR_W       4  log2(DEPTH); pointer width
//  IRQ_THRESH   1  irq asserts when count >= IRQ_THRESH; valid range 1..DEPTH
// PORTS
//  br_clk_16  in   1         16x baud clock; all logic on posedge
//  reset      in   1         asynchronous, active-low reset
//  rx_valid   in   1         receiver RX_STATUS; high >= 1 cycle per completed byte
//  rx_data    in   8         receiver RX_DATA; stable while rx_valid is high
//  rd_en      in   1         read request, one byte per cycle asserted
//  rd_data    out  8         byte popped by the last accepted read
//  rd_valid   out  1         1-cycle pulse: rd_data updated this cycle
//  empty      out  1         count == 0
//  full       out  1         count == DEPTH
//  count      out  ADDR_W+1  bytes currently held, 0..DEPTH
//  irq        out  1         count >= IRQ_THRESH
//  overrun    out  1         sticky: a byte was dropped (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, reset==0): wr_ptr=rd_ptr=0, count=0, rd_data=8'h00, rd_valid=0,
//    overrun=0, rx_valid_d=0; so empty=1, full=0, irq=0. Memory contents not cleared.
//    Reset mid-operation discards all buffered bytes. Reads and writes are not accepted
//    while reset is low.
//  - Write detect: wr_req = rx_valid & ~rx_valid_d (rising edge; rx_valid_d is rx_valid
//    registered). A level held over several cycles writes exactly once.
//  - Write accept: wr_req & (~full | rd_acc). Stores rx_data at mem[wr_ptr], and
//    wr_ptr <= wr_ptr+1, wrapping at DEPTH (ADDR_W-bit natural wrap).
//  - Read accept: rd_acc = rd_en & ~empty. rd_data <= mem[rd_ptr], rd_ptr <= rd_ptr+1
//    (wrap), and rd_valid=1 on the next cycle (latency 1). rd_en while empty is ignored:
//    rd_valid=0 and rd_data holds its value.
//  - Simultaneous write and read:
//    - Not empty (including full): both accepted; count unchanged. A full FIFO accepts
//      the write because the read frees a slot.
//    - Empty: write accepted, read ignored; no bypass. The byte is readable next cycle.
//  - Full, write, no read: byte dropped; pointers and count unchanged; overrun handling
//    per CONFIGURATION.
//  - count: +1 on write only, -1 on read only, unchanged on both or neither.
//    Never exceeds DEPTH and never goes below 0.
//  - empty, full and irq are combinational from the count register (no extra latency).
//  - No state machine beyond pointers and count; the FIFO is ready every cycle.
// CONFIGURATION
//  Macro UART_RX_FIFO_OVERRUN_EN.
//  - Defined: overrun is set on the cycle after a dropped write and stays set until reset.
//    irq is also forced high while overrun=1.
//  - Undefined: overrun is tied to 0, dropped bytes are silently lost, and irq follows
//    count only.
// TESTING
//  1 Reset, then one rx_valid pulse with rx_data=8'hA5 -> count=1, empty=0, irq=1;
//    rd_en 1 cycle -> next cycle rd_valid=1, rd_data=8'hA5, count=0, empty=1.
//  2 rx_valid held high 5 cycles with rx_data=8'h3C -> exactly one write; count=1.
//  3 Write 16 bytes 8'h00..8'h0F -> full=1, count=16; read 16 -> data 00..0F in order;
//    write 8'h10 -> stored at slot 0 (pointer wrap); reads back 8'h10.
//  4 Full FIFO plus 17th byte 8'hEE with no read -> count stays 16, EE never read;
//    overrun=1 if UART_RX_FIFO_OVERRUN_EN is defined, else 0.
//  5 count=3, write 8'h77 and rd_en in the same cycle -> count stays 3, oldest byte
//    returned; empty FIFO with the same stimulus -> count=1, rd_valid=0.
//  6 count=5, assert reset low mid-stream -> immediately count=0, empty=1, rd_valid=0,
//    overrun=0; first byte after release reads back first.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receiver/CPU side and the uart_rx_fifo byte buffer.
// master drives receive strobes and read requests; slave (the FIFO) returns data and status.
interface uart_rx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rd_en;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              irq;
    logic              overrun;

    modport master (
        output rx_valid, rx_data, rd_en,
        input  rd_data, rd_valid, empty, full, count, irq, overrun
    );

    modport slave (
        input  rx_valid, rx_data, rd_en,
        output rd_data, rd_valid, empty, full, count, irq, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular byte FIFO behind the UART receiver; one write per rx_valid rising edge.
// Optional sticky overrun flag (and irq forcing) enabled by macro UART_RX_FIFO_OVERRUN_EN.
module uart_rx_fifo #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int IRQ_THRESH = 1
) (
    input  logic           br_clk_16,
    input  logic           reset,
    uart_rx_fifo_if.slave  bus
);
    localparam logic [ADDR_W:0]   FULL_CNT = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   IRQ_CNT  = IRQ_THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rx_valid_dly_q;
    logic              empty, full, wr_req, wr_acc, rd_acc;
`ifdef UART_RX_FIFO_OVERRUN_EN
    logic              overrun_q, overrun_d;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        empty  = (count_q == '0);
        full   = (count_q == FULL_CNT);
        wr_req = bus.rx_valid & ~rx_valid_dly_q;
        rd_acc = bus.rd_en & ~empty;
        // A full FIFO still takes the byte when a read frees a slot in the same cycle.
        wr_acc = wr_req & (~full | rd_acc);

        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            rd_data_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

`ifdef UART_RX_FIFO_OVERRUN_EN
    always_comb begin
        overrun_d = overrun_q | (wr_req & full & ~rd_acc);
    end
`endif

    always_ff @(posedge br_clk_16 or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            rd_data_q      <= 8'h00;
            rd_valid_q     <= 1'b0;
            rx_valid_dly_q <= 1'b0;
`ifdef UART_RX_FIFO_OVERRUN_EN
            overrun_q      <= 1'b0;
`endif
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            rd_data_q      <= rd_data_d;
            rd_valid_q     <= rd_valid_d;
            rx_valid_dly_q <= bus.rx_valid;
`ifdef UART_RX_FIFO_OVERRUN_EN
            overrun_q      <= overrun_d;
`endif
        end
    end

    // NOTE: storage has no reset; the pointers and count alone define which slots are valid.
    always_ff @(posedge br_clk_16) begin
        if (wr_acc && reset) mem_q[wr_ptr_q] <= bus.rx_data;
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.count    = count_q;
`ifdef UART_RX_FIFO_OVERRUN_EN
    assign bus.overrun  = overrun_q;
    assign bus.irq      = (count_q >= IRQ_CNT) | overrun_q;
`else
    assign bus.overrun  = 1'b0;
    assign bus.irq      = (count_q >= IRQ_CNT);
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: writes push expected bytes, a negedge monitor pops on rd_valid.
// Status flags are compared against the length of the bench's own FIFO model.
module tb_uart_rx_fifo;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
`ifdef UART_RX_FIFO_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic br_clk_16 = 1'b0;
    logic reset     = 1'b0;
    int   n_tests   = 0;
    int   n_fail    = 0;
    bit   exp_ovr   = 1'b0;
    logic [7:0] model [$];

    uart_rx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .IRQ_THRESH(1)) dut (
        .br_clk_16 (br_clk_16),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 br_clk_16 = ~br_clk_16;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rd_valid pulse must carry the oldest byte the model holds.
    always @(negedge br_clk_16) begin
        if (reset && bus.rd_valid) begin
            if (model.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rd_unexpected: got rd_data %0h, expected no read", bus.rd_data);
            end else begin
                check("rd_data", 32'(bus.rd_data), 32'(model.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge br_clk_16);
        #1;
    endtask

    task automatic check_flags(input string tag);
        int n;
        n = model.size();
        check({tag, "_count"}, 32'(bus.count), 32'(n));
        check({tag, "_empty"}, 32'(bus.empty), 32'(n == 0));
        check({tag, "_full"},  32'(bus.full),  32'(n == DEPTH));
        check({tag, "_irq"},   32'(bus.irq),   32'((n >= 1) || exp_ovr));
        check({tag, "_ovr"},   32'(bus.overrun), 32'(exp_ovr));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rd_en = 1'b0;
        model.delete();
        exp_ovr = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Pulse rx_valid for one cycle then hold it low one cycle so the next pulse is a fresh edge.
    task automatic write_byte(input logic [7:0] b, input bit accepted);
        bus.rx_data = b;
        bus.rx_valid = 1'b1;
        tick();
        if (accepted) model.push_back(b);
        bus.rx_valid = 1'b0;
        tick();
    endtask

    task automatic read_byte();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        tick();
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rd_en    = 1'b0;
        do_reset();
        check_flags("reset");
        check("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("reset_rd_data",  32'(bus.rd_data),  32'h00);

        // 1: single byte in and out
        write_byte(8'hA5, 1'b1);
        check_flags("t1_wr");
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check("t1_rd_valid", 32'(bus.rd_valid), 32'd1);
        check("t1_rd_data",  32'(bus.rd_data),  32'hA5);
        tick();
        check("t1_rd_valid_pulse", 32'(bus.rd_valid), 32'd0);
        check_flags("t1_rd");

        // 2: level held 5 cycles writes exactly once
        bus.rx_data = 8'h3C;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        model.push_back(8'h3C);
        bus.rx_valid = 1'b0;
        tick();
        check_flags("t2_held");
        read_byte();
        check_flags("t2_drain");

        // 3: fill from a fresh reset, drain in order, then wrap to slot 0
        do_reset();
        for (int i = 0; i < DEPTH; i++) write_byte(8'(i), 1'b1);
        check_flags("t3_full");
        for (int i = 0; i < DEPTH; i++) read_byte();
        check_flags("t3_drained");
        write_byte(8'h10, 1'b1);
        read_byte();
        check_flags("t3_wrap");

        // 4: write into a full FIFO with no read is dropped
        for (int i = 0; i < DEPTH; i++) write_byte(8'(8'h20 + i), 1'b1);
        write_byte(8'hEE, 1'b0);
        exp_ovr = OVR_EN;
        check_flags("t4_drop");
        for (int i = 0; i < DEPTH; i++) read_byte();
        check_flags("t4_drained");

        // 5: simultaneous write+read, non-empty then empty
        do_reset();
        check_flags("t5_reset");
        write_byte(8'h51, 1'b1);
        write_byte(8'h52, 1'b1);
        write_byte(8'h53, 1'b1);
        bus.rx_data = 8'h77;
        bus.rx_valid = 1'b1;
        bus.rd_en = 1'b1;
        tick();
        model.push_back(8'h77);
        bus.rx_valid = 1'b0;
        bus.rd_en = 1'b0;
        check("t5_both_count", 32'(bus.count), 32'd3);
        check("t5_both_rd_valid", 32'(bus.rd_valid), 32'd1);
        check("t5_both_rd_data", 32'(bus.rd_data), 32'h51);
        tick();
        for (int i = 0; i < 3; i++) read_byte();
        check_flags("t5_drained");
        bus.rx_data = 8'h78;
        bus.rx_valid = 1'b1;
        bus.rd_en = 1'b1;
        tick();
        model.push_back(8'h78);
        bus.rx_valid = 1'b0;
        bus.rd_en = 1'b0;
        check("t5_empty_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("t5_empty_rd_data", 32'(bus.rd_data), 32'h77);
        check("t5_empty_count", 32'(bus.count), 32'd1);
        tick();
        read_byte();
        check_flags("t5_empty_drained");

        // 6: asynchronous reset mid-stream while a read result is presented
        for (int i = 0; i < 6; i++) write_byte(8'(8'h90 + i), 1'b1);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check("t6_pre_count", 32'(bus.count), 32'd5);
        check("t6_pre_rd_valid", 32'(bus.rd_valid), 32'd1);
        check("t6_pre_rd_data", 32'(bus.rd_data), 32'h90);
        reset = 1'b0;
        #1;
        model.delete();
        exp_ovr = 1'b0;
        check_flags("t6_async");
        check("t6_rd_valid", 32'(bus.rd_valid), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        write_byte(8'hC3, 1'b1);
        write_byte(8'hC4, 1'b1);
        read_byte();
        read_byte();
        check_flags("t6_after");

        tick();
        check("model_drained", 32'(model.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
